// File: rtl/stats_vector_deserializer.sv
// Deserializes a start-bit-framed, MSB-first statistics stream into a parallel
// vector and keeps saturating good/bad frame counters.
module stats_vector_deserializer #(
  parameter int VEC_WIDTH = 30,
  parameter int GOOD_BIT  = 0,
  parameter int BAD_BIT   = 1
) (
  input  logic                 rx_clk0,
  input  logic                 rx_axis_aresetn,
  input  logic                 stats_serial,
  input  logic                 CntClr,
  output logic [VEC_WIDTH-1:0] stats_vector,
  output logic                 stats_valid,
  output logic [31:0]          GoodFrm_Cnt,
  output logic [31:0]          BadFrm_Cnt,
  output logic                 busy
);

  localparam int CW = (VEC_WIDTH > 2) ? $clog2(VEC_WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state, state_next;
  logic [CW-1:0]        bit_cnt, bit_cnt_next;
  logic [VEC_WIDTH-1:0] capture, capture_next;
  logic                 done, done_next;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    capture_next = capture;
    done_next    = 1'b0;
    unique case (state)
      IDLE: begin
        if (stats_serial) begin
          state_next   = SHIFT;
          bit_cnt_next = CW'(VEC_WIDTH - 1);
        end
      end
      SHIFT: begin
        // Line is pure data here; a 1 never restarts the frame.
        capture_next = {capture[VEC_WIDTH-2:0], stats_serial};
        if (bit_cnt == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          bit_cnt_next = bit_cnt - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge rx_clk0 or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      state   <= IDLE;
      bit_cnt <= '0;
      capture <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      capture <= capture_next;
      done    <= done_next;
      busy    <= (state_next == SHIFT);
    end
  end

  // Publish one cycle after the last bit so partial captures never leak out.
  always_ff @(posedge rx_clk0 or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      stats_vector <= '0;
      stats_valid  <= 1'b0;
    end else begin
      stats_valid <= done;
      if (done) stats_vector <= capture;
    end
  end

  // Clear has priority over a coincident increment; counts stick at all-ones.
  always_ff @(posedge rx_clk0 or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      GoodFrm_Cnt <= '0;
      BadFrm_Cnt  <= '0;
    end else if (CntClr) begin
      GoodFrm_Cnt <= '0;
      BadFrm_Cnt  <= '0;
    end else if (stats_valid) begin
      if (stats_vector[GOOD_BIT] && (GoodFrm_Cnt != '1)) GoodFrm_Cnt <= GoodFrm_Cnt + 32'd1;
      if (stats_vector[BAD_BIT]  && (BadFrm_Cnt  != '1)) BadFrm_Cnt  <= BadFrm_Cnt  + 32'd1;
    end
  end

endmodule

// File: tb/tb_stats_vector_deserializer.sv
// Scoreboard bench for stats_vector_deserializer: a 30-bit and a 26-bit
// instance share clock and reset; expected captures are queued at stimulus time.
module tb_stats_vector_deserializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        serial30, serial26, clr;
  logic [29:0] vec30;
  logic [25:0] vec26;
  logic        valid30, valid26, busy30, busy26;
  logic [31:0] good30, bad30, good26, bad26;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busy26_cycles = 0;

  typedef struct {
    logic [29:0] vec;
    int          cyc;
  } exp_t;

  exp_t q30[$];
  exp_t q26[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stats_vector_deserializer #(.VEC_WIDTH(30), .GOOD_BIT(0), .BAD_BIT(1)) dut (
    .rx_clk0(clk), .rx_axis_aresetn(rst_n), .stats_serial(serial30), .CntClr(clr),
    .stats_vector(vec30), .stats_valid(valid30), .GoodFrm_Cnt(good30),
    .BadFrm_Cnt(bad30), .busy(busy30)
  );

  stats_vector_deserializer #(.VEC_WIDTH(26), .GOOD_BIT(0), .BAD_BIT(1)) dut26 (
    .rx_clk0(clk), .rx_axis_aresetn(rst_n), .stats_serial(serial26), .CntClr(clr),
    .stats_vector(vec26), .stats_valid(valid26), .GoodFrm_Cnt(good26),
    .BadFrm_Cnt(bad26), .busy(busy26)
  );

  // Scoreboard monitors: every pulse must match the queue head in value and cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid30 === 1'b1) begin
      exp_t e;
      checks++;
      if (q30.size() == 0) begin
        failures++;
        $display("FAIL valid30_unexpected: got vector=%h at cycle %0d, required no pulse", vec30, cyc);
      end else begin
        e = q30.pop_front();
        if (vec30 !== e.vec || cyc != e.cyc) begin
          failures++;
          $display("FAIL capture30: got vector=%h cycle=%0d, required vector=%h cycle=%0d",
                   vec30, cyc, e.vec, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && busy26 === 1'b1) busy26_cycles++;
    if (rst_n === 1'b1 && valid26 === 1'b1) begin
      exp_t e;
      checks++;
      if (q26.size() == 0) begin
        failures++;
        $display("FAIL valid26_unexpected: got vector=%h at cycle %0d, required no pulse", vec26, cyc);
      end else begin
        e = q26.pop_front();
        if (vec26 !== e.vec[25:0] || cyc != e.cyc) begin
          failures++;
          $display("FAIL capture26: got vector=%h cycle=%0d, required vector=%h cycle=%0d",
                   vec26, cyc, e.vec[25:0], e.cyc);
        end
      end
    end
  end

  // Start bit plus 30 data bits; leaves the last data bit on the line.
  task automatic send30(input logic [29:0] v, input bit expect_out);
    exp_t e;
    @(negedge clk);
    serial30 = 1'b1;
    e.vec = v;
    e.cyc = cyc + 32;
    if (expect_out) q30.push_back(e);
    for (int i = 29; i >= 0; i--) begin
      @(negedge clk);
      serial30 = v[i];
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    serial30 = 1'b0;
    serial26 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic check_counts(input string name, input logic [31:0] g, input logic [31:0] b);
    checks++;
    if (good30 !== g || bad30 !== b) begin
      failures++;
      $display("FAIL %s: got good=%h bad=%h, required good=%h bad=%h", name, good30, bad30, g, b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; serial30 = 1'b0; serial26 = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (vec30 !== '0 || valid30 !== 1'b0 || busy30 !== 1'b0 || good30 !== '0 || bad30 !== '0) begin
      failures++;
      $display("FAIL reset_state: got vec=%h valid=%b busy=%b good=%h bad=%h, required all zero",
               vec30, valid30, busy30, good30, bad30);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame();
    send30(30'h2000_0001, 1'b1);
    idle(35);
    check_counts("single_frame_counts", 32'd1, 32'd0);
    checks++;
    if (vec30 !== 30'h2000_0001) begin
      failures++;
      $display("FAIL single_frame_hold: got %h, required %h", vec30, 30'h2000_0001);
    end
  endtask

  task automatic test_back_to_back();
    pulse_clear();
    check_counts("clear_counts", 32'd0, 32'd0);
    send30(30'h0000_0002, 1'b1);
    send30(30'h3FFF_FFFF, 1'b1);
    idle(35);
    check_counts("back_to_back_counts", 32'd1, 32'd2);
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    serial30 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      serial30 = i[0];
    end
    @(negedge clk);
    rst_n = 1'b0;
    serial30 = 1'b0;
    #1;
    checks++;
    if (busy30 !== 1'b0 || good30 !== '0 || vec30 !== '0) begin
      failures++;
      $display("FAIL reset_mid_frame_async: got busy=%b good=%h vec=%h, required all zero",
               busy30, good30, vec30);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send30(30'h0000_0001, 1'b1);
    idle(35);
    check_counts("reset_mid_frame_counts", 32'd1, 32'd0);
  endtask

  task automatic test_saturation();
    pulse_clear();
    @(negedge clk);
    force dut.GoodFrm_Cnt = 32'hFFFF_FFFE;
    #1;
    release dut.GoodFrm_Cnt;
    for (int i = 0; i < 3; i++) send30(30'h0000_0001, 1'b1);
    idle(35);
    check_counts("saturation", 32'hFFFF_FFFF, 32'd0);
  endtask

  task automatic test_clear_wins();
    int waited = 0;
    pulse_clear();
    send30(30'h0000_0001, 1'b1);
    idle(35);
    check_counts("pre_clear_count", 32'd1, 32'd0);
    send30(30'h0000_0001, 1'b1);
    @(negedge clk);
    serial30 = 1'b0;
    while (valid30 !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (valid30 !== 1'b1) begin
      failures++;
      $display("FAIL clear_wins_timeout: got no stats_valid in 100 cycles, required a pulse");
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_counts("clear_wins", 32'd0, 32'd0);
    checks++;
    if (vec30 !== 30'h0000_0001) begin
      failures++;
      $display("FAIL clear_keeps_vector: got %h, required %h", vec30, 30'h0000_0001);
    end
    idle(5);
  endtask

  task automatic test_width26_all_ones();
    exp_t e;
    logic [25:0] v = 26'h3FF_FFFF;
    busy26_cycles = 0;
    @(negedge clk);
    serial26 = 1'b1;
    e.vec = {4'h0, v};
    e.cyc = cyc + 28;
    q26.push_back(e);
    for (int i = 25; i >= 0; i--) begin
      @(negedge clk);
      serial26 = v[i];
    end
    idle(35);
    checks++;
    if (busy26_cycles != 26) begin
      failures++;
      $display("FAIL busy26_cycles: got %0d, required 26", busy26_cycles);
    end
    checks++;
    if (good26 !== 32'd1 || bad26 !== 32'd1) begin
      failures++;
      $display("FAIL width26_counts: got good=%h bad=%h, required 1/1", good26, bad26);
    end
  endtask

  task automatic test_drain();
    checks++;
    if (q30.size() != 0 || q26.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses: got %0d/%0d pending, required 0/0", q30.size(), q26.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_saturation();
    test_clear_wins();
    test_width26_all_ones();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
